// File: rtl/fp_cmp_arbiter.sv
// fp_cmp_arbiter: shares one pipelined floating-point greater_than comparator
// among NREQ slab-test requesters. One operand pair is granted per cycle, a
// tag pipeline follows each pair through the comparator latency, and each
// result is returned to the requester that issued it.
//
// Build option: FP_CMP_ARB_RR_EN selects round-robin arbitration; when it is
// undefined, arbitration is fixed priority (lowest index wins) and the
// round-robin pointer does not exist.
//
// Parameters: NREQ (2..8) requesters, WIDTH operand MSB index (operands are
// WIDTH+1 bits), CMP_LAT comparator latency in edges (>= 1).
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is a
//                        combinational one-hot grant
//   req_a, req_b         flattened operands, requester i in slice i
//   hold                 blocks new grants while high
//   cmp_inA, cmp_inB     registered operands to the comparator
//   cmp_greater          comparator result
//   rsp_valid            one-hot single-cycle result strobe
//   rsp_greater, rsp_id  result and requester index, valid with rsp_valid
//   idle                 no grant pending, nothing in flight
module fp_cmp_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 33,
  parameter int unsigned CMP_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*(WIDTH+1)-1:0]  req_a,
  input  logic [NREQ*(WIDTH+1)-1:0]  req_b,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       hold,
  output logic [WIDTH:0]             cmp_inA,
  output logic [WIDTH:0]             cmp_inB,
  input  logic                       cmp_greater,
  output logic [NREQ-1:0]            rsp_valid,
  output logic                       rsp_greater,
  output logic [2:0]                 rsp_id,
  output logic                       idle
);

  localparam int unsigned OPW = WIDTH + 1;
  localparam int unsigned IDW = 3;

  logic [NREQ-1:0]             ready_c;
  logic [IDW-1:0]              gnt_id;
  logic                        found;
  logic                        accept;
  logic [OPW-1:0]              gnt_a;
  logic [OPW-1:0]              gnt_b;
  logic [CMP_LAT:0]            tag_v;
  logic [CMP_LAT:0][IDW-1:0]   tag_id;

`ifdef FP_CMP_ARB_RR_EN
  logic [IDW-1:0] ptr;
`endif

  // Grant: first pass covers indices at or above ptr, second pass wraps to
  // the lowest valid index. Without round robin only the second pass exists.
  always_comb begin
    ready_c = '0;
    gnt_id  = '0;
    found   = 1'b0;
    if (rst && !hold) begin
`ifdef FP_CMP_ARB_RR_EN
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (IDW'(i) >= ptr)) begin
          found      = 1'b1;
          gnt_id     = IDW'(i);
          ready_c[i] = 1'b1;
        end
      end
`endif
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i]) begin
          found      = 1'b1;
          gnt_id     = IDW'(i);
          ready_c[i] = 1'b1;
        end
      end
    end
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ready_c[i]) begin
        gnt_a = req_a[i*OPW +: OPW];
        gnt_b = req_b[i*OPW +: OPW];
      end
    end
  end

  assign req_ready = ready_c;
  assign accept    = |(req_valid & ready_c);

`ifdef FP_CMP_ARB_RR_EN
  // Round-robin pointer: one past the last accepted requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end
`endif

  // Operand register, tag pipeline and response register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_inA     <= '0;
      cmp_inB     <= '0;
      tag_v       <= '0;
      tag_id      <= '0;
      rsp_valid   <= '0;
      rsp_greater <= 1'b0;
      rsp_id      <= '0;
    end else begin
      if (accept) begin
        cmp_inA <= gnt_a;
        cmp_inB <= gnt_b;
      end
      tag_v  <= {tag_v[CMP_LAT-1:0], accept};
      tag_id <= {tag_id[CMP_LAT-1:0], gnt_id};
      if (tag_v[CMP_LAT]) begin
        rsp_valid   <= NREQ'(1) << tag_id[CMP_LAT];
        rsp_greater <= cmp_greater;
        rsp_id      <= tag_id[CMP_LAT];
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign idle = ~|tag_v & ~accept & ~|rsp_valid;

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Testbench for fp_cmp_arbiter: table-driven grant vectors plus directed
// multi-cycle sequences, with a CMP_LAT=3 greater_than comparator model.
module tb_fp_cmp_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned WIDTH = 33;
  localparam int unsigned CMP_LAT = 3;
  localparam int unsigned OPW = WIDTH + 1;

  localparam logic [33:0] ONE = 34'h13FF00000;
  localparam logic [33:0] TWO = 34'h140000000;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*OPW-1:0]   req_a;
  logic [NREQ*OPW-1:0]   req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  hold;
  logic [WIDTH:0]        cmp_inA;
  logic [WIDTH:0]        cmp_inB;
  logic                  cmp_greater;
  logic [NREQ-1:0]       rsp_valid;
  logic                  rsp_greater;
  logic [2:0]            rsp_id;
  logic                  idle;

  fp_cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CMP_LAT(CMP_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .hold(hold), .cmp_inA(cmp_inA), .cmp_inB(cmp_inB),
    .cmp_greater(cmp_greater), .rsp_valid(rsp_valid), .rsp_greater(rsp_greater),
    .rsp_id(rsp_id), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: sign/magnitude compare of normal numbers, 3-edge latency.
  function automatic logic fp_gt(input logic [33:0] a, input logic [33:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  logic [CMP_LAT-1:0] cmp_pipe = '0;
  always @(posedge clk) cmp_pipe <= {cmp_pipe[CMP_LAT-2:0], fp_gt(cmp_inA, cmp_inB)};
  assign cmp_greater = cmp_pipe[CMP_LAT-1];

  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_ops(input int i, input logic [33:0] a, input logic [33:0] b);
    req_a[i*OPW +: OPW] = a;
    req_b[i*OPW +: OPW] = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       hold;
    logic [3:0] exp_rr;
    logic [3:0] exp_fp;
  } vec_t;

  vec_t tbl [10];
  logic [3:0] rv [16];
  logic       rg [16];
  logic [2:0] rid [16];
  logic [3:0] gr [16];
  logic       idl [16];
  int         exp_id [6];
  int         exp_fx [4];
  int         cnt;
  logic [3:0] exp_v;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Grant table; rows are applied back to back from ptr=0 after reset.
    tbl[0] = '{4'b0000, 1'b0, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1010, 1'b0, 4'b0010, 4'b0010};
    tbl[2] = '{4'b1010, 1'b0, 4'b1000, 4'b0010};
    tbl[3] = '{4'b1111, 1'b1, 4'b0000, 4'b0000};
    tbl[4] = '{4'b1100, 1'b0, 4'b0100, 4'b0100};
    tbl[5] = '{4'b0101, 1'b0, 4'b0001, 4'b0001};
    tbl[6] = '{4'b1001, 1'b0, 4'b1000, 4'b0001};
    tbl[7] = '{4'b1001, 1'b0, 4'b0001, 4'b0001};
    tbl[8] = '{4'b0001, 1'b0, 4'b0001, 4'b0001};
    tbl[9] = '{4'b0000, 1'b0, 4'b0000, 4'b0000};
`ifdef FP_CMP_ARB_RR_EN
    exp_id = '{0, 1, 2, 3, 0, 1};
    exp_fx = '{3, 1, 3, 1};
`else
    exp_id = '{0, 0, 0, 0, 0, 0};
    exp_fx = '{1, 1, 1, 1};
`endif

    rst = 1'b0; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;

    // Reset state, with requests present to show grants are suppressed.
    #2;
    req_valid = 4'hF;
    #1;
    chk("reset req_ready", 64'(req_ready), 64'h0);
    chk("reset idle", 64'(idle), 64'h1);
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset rsp_greater", 64'(rsp_greater), 64'h0);
    chk("reset rsp_id", 64'(rsp_id), 64'h0);
    chk("reset cmp_inA", 64'(cmp_inA), 64'h0);
    chk("reset cmp_inB", 64'(cmp_inB), 64'h0);
    step(1);
    req_valid = '0;
    rst = 1'b1;
    step(2);

    // Table-driven grant vectors.
    for (int r = 0; r < 10; r++) begin
      req_valid = tbl[r].valid;
      hold = tbl[r].hold;
      #1;
`ifdef FP_CMP_ARB_RR_EN
      chk($sformatf("grant row %0d", r), 64'(req_ready), 64'(tbl[r].exp_rr));
`else
      chk($sformatf("grant row %0d", r), 64'(req_ready), 64'(tbl[r].exp_fp));
`endif
      step(1);
    end
    req_valid = '0; hold = 1'b0;
    step(6);

    // Single request from requester 2.
    set_ops(2, TWO, ONE);
    req_valid = 4'b0100;
    #1;
    chk("single ready", 64'(req_ready), 64'b0100);
    step(1);
    req_valid = '0;
    chk("single cmp_inA", 64'(cmp_inA), 64'(TWO));
    chk("single cmp_inB", 64'(cmp_inB), 64'(ONE));
    step(3);
    chk("single early rsp", 64'(rsp_valid), 64'h0);
    step(1);
    chk("single rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("single rsp_greater", 64'(rsp_greater), 64'h1);
    chk("single rsp_id", 64'(rsp_id), 64'h2);
    chk("single idle busy", 64'(idle), 64'h0);
    step(1);
    chk("single rsp drop", 64'(rsp_valid), 64'h0);
    chk("single idle", 64'(idle), 64'h1);

    // Back-to-back from requester 0 with alternating operands.
    for (int k = 0; k < 10; k++) begin
      if (k < 5) begin
        req_valid = 4'b0001;
        if (k % 2 == 0) set_ops(0, TWO, ONE);
        else set_ops(0, ONE, TWO);
      end else begin
        req_valid = '0;
      end
      step(1);
      rv[k] = rsp_valid;
      rg[k] = rsp_greater;
    end
    chk("b2b before", 64'(rv[3]), 64'h0);
    for (int k = 4; k < 9; k++) begin
      chk($sformatf("b2b valid %0d", k - 4), 64'(rv[k]), 64'b0001);
      chk($sformatf("b2b greater %0d", k - 4), 64'(rg[k]), 64'((k - 4) % 2 == 0));
    end
    chk("b2b after", 64'(rv[9]), 64'h0);
    step(2);

    // Hold after three accepts from requester 1.
    set_ops(1, TWO, ONE);
    for (int k = 0; k < 10; k++) begin
      req_valid = 4'b0010;
      hold = (k >= 3);
      #1;
      if (k >= 3) chk($sformatf("hold ready %0d", k), 64'(req_ready), 64'h0);
      step(1);
      rv[k] = rsp_valid;
      idl[k] = idle;
    end
    req_valid = '0; hold = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) if (rv[k] == 4'b0010) cnt++;
    chk("hold rsp count", 64'(cnt), 64'd3);
    chk("hold last rsp", 64'(rv[6]), 64'b0010);
    chk("hold idle busy", 64'(idl[6]), 64'h0);
    chk("hold idle", 64'(idl[7]), 64'h1);
    step(2);

    // Reset two cycles after an accept.
    set_ops(2, TWO, ONE);
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    step(2);
    rst = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst rsp_greater", 64'(rsp_greater), 64'h0);
    chk("rst rsp_id", 64'(rsp_id), 64'h0);
    chk("rst cmp_inA", 64'(cmp_inA), 64'h0);
    chk("rst req_ready", 64'(req_ready), 64'h0);
    chk("rst idle", 64'(idle), 64'h1);
    step(1);
    req_valid = '0;
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (rsp_valid != '0) cnt++;
    end
    chk("rst no late rsp", 64'(cnt), 64'h0);

    // Full contention starting from ptr=0.
    for (int i = 0; i < 4; i++) set_ops(i, TWO, ONE);
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 6) ? 4'hF : 4'h0;
      #1;
      gr[k] = req_ready;
      step(1);
      rv[k] = rsp_valid;
      rid[k] = rsp_id;
    end
    for (int k = 0; k < 6; k++) begin
      exp_v = 4'b0001 << exp_id[k];
      chk($sformatf("contend grant %0d", k), 64'(gr[k]), 64'(exp_v));
      chk($sformatf("contend rsp_valid %0d", k), 64'(rv[k + 4]), 64'(exp_v));
      chk($sformatf("contend rsp_id %0d", k), 64'(rid[k + 4]), 64'(exp_id[k]));
    end

    // Requesters 1 and 3 continuously valid.
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b1010;
      #1;
      exp_v = 4'b0001 << exp_fx[k];
      chk($sformatf("pair grant %0d", k), 64'(req_ready), 64'(exp_v));
      step(1);
    end
    req_valid = '0;
    step(6);
    chk("final idle", 64'(idle), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_cmp_arbiter.md
# fp_cmp_arbiter

Shares one pipelined floating-point `greater_than` comparator (11-bit exponent, 20-bit fraction, 34-bit FloPoCo word with 2 exception bits) among `NREQ` slab-test requesters in the ray/AABB datapath.
- Arbitrates one operand pair per cycle onto the comparator.
- Tracks each pair through the comparator latency with a tag pipeline.
- Returns every result to its originating requester.
- Sits between the per-axis slab units and a single comparator instance, wired at top level.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 33: operand MSB index; operands are `WIDTH+1` = 34 bits.
- `CMP_LAT`, 3: clock edges from a `cmp_inA`/`cmp_inB` update to the matching valid `cmp_greater`. The top level sets it to the instantiated comparator's latency.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has an operand pair.
- `req_a`  in  NREQ*(WIDTH+1)  flattened A operands; requester i occupies slice i.
- `req_b`  in  NREQ*(WIDTH+1)  flattened B operands.
- `req_ready`  out  NREQ  one-hot grant, combinational; accept = `req_valid[i] & req_ready[i]` at an edge.
- `hold`  in  1  while high, no new grants are issued.
- `cmp_inA`, `cmp_inB`  out  WIDTH+1  registered operands to the comparator.
- `cmp_greater`  in  1  comparator result.
- `rsp_valid`  out  NREQ  one-hot single-cycle result strobe.
- `rsp_greater`  out  1  result, valid with `rsp_valid`.
- `rsp_id`  out  3  index of the requester being answered.
- `idle`  out  1  high when no grant is pending and no tag is in flight.

## Operation
- **Grant, round robin.**
  - Scan starts at pointer `ptr` and wraps modulo NREQ.
  - The first i with `req_valid[i]` gets `req_ready[i]=1`; all other ready bits are 0.
  - No grant while `hold=1`.
- **Pointer update.** On an accept by i, `ptr <= (i+1) mod NREQ`. No accept leaves `ptr` unchanged.
- **Operand register.** On an accept, `cmp_inA/cmp_inB` load the granted slices. Without an accept they keep their value; the tag is invalid, so the comparator output is ignored.
- **Tag pipeline.**
  - A shift register of depth `CMP_LAT+1`; each entry is {valid, id}.
  - Stage 0 loads {accept, granted id} every edge.
  - Throughput is one accept per cycle. There is no backpressure on responses: requesters must sink every `rsp_valid`.
- **Response register.**
  - When the final tag stage is valid, the response registers load `rsp_greater<=cmp_greater`, `rsp_id<=id`, and `rsp_valid<=onehot(id)`.
  - Otherwise `rsp_valid<=0` and `rsp_greater`/`rsp_id` hold.
- **`idle`.** `idle = ~|tag_valid & ~|(req_valid & req_ready) & ~|rsp_valid`.
- **Hold.** Raising `hold` mid-stream lets all in-flight tags complete. `idle` rises once the pipeline drains.
- **Simultaneous events.** An accept and a response to the same requester in the same cycle are legal and independent.

## Timing
- Reset values, asynchronous while `rst=0`:
  - `ptr=0`, all tag valids 0, `cmp_inA=cmp_inB=0`.
  - `rsp_valid=0`, `rsp_greater=0`, `rsp_id=0`, `idle=1`.
  - `req_ready=0` while in reset.
- Latency: an accept at edge E0 produces `rsp_valid` high for the one cycle following edge E0+CMP_LAT+1.
- Reset asserted mid-operation discards all in-flight results; no `rsp_valid` follows for them after reset release.
- `req_ready` depends only on `req_valid`, `hold`, `ptr`, and reset; it never depends on `cmp_greater`.

## Configuration
- `FP_CMP_ARB_RR_EN` defined: round-robin arbitration as described.
- `FP_CMP_ARB_RR_EN` undefined:
  - Fixed priority; the lowest index with `req_valid` wins.
  - `ptr` is removed.
  - All other behaviour is identical.

## Test plan
Encoding: 1.0 = 34'h13FF00000, 2.0 = 34'h140000000. Each case uses a comparator model with `CMP_LAT=3`.
- **Single request.** Requester 2 presents A=2.0, B=1.0 for one accept at E0. Required: `rsp_valid=4'b0100`, `rsp_greater=1`, `rsp_id=2` in the cycle after E0+4, and `idle` returns to 1 one cycle later.
- **Back-to-back.** Requester 0 stays valid for 5 cycles with alternating (2.0,1.0) and (1.0,2.0). Required: 5 consecutive responses with `rsp_greater` = 1,0,1,0,1 and no gaps.
- **Full contention (RR on).** All 4 requesters valid continuously. Required: grant order 0,1,2,3,0,1; the `rsp_id` sequence is identical, delayed 4 cycles.
- **Hold.** 3 accepts, then `hold=1`. Required: `req_ready=0` while held, 3 responses still arrive, and `idle=1` after the last one.
- **Reset mid-flight.** Pull `rst` low 2 cycles after an accept. Required: all outputs at reset values immediately and no response after release.
- **Fixed priority (macro undefined).** Requesters 1 and 3 valid continuously. Required: every grant goes to 1 and requester 3 is starved.
